// File: rtl/motion_seq.sv
// motion_seq: sequences the shared ALU through one PI motor update per go; optional macro ANTI_WINDUP_EN holds the integrator after output saturation
module motion_seq #(
  parameter int MULT_CYC = 2,
  parameter int INT_DEC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [11:0] err_in,
  input  logic [15:0] dst,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Icomp,
  output logic [11:0] Intgrl,
  output logic [11:0] Error,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, INTG, ICOMP, PCOMP, ACC_R, RHT, ACC_L, LFT} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q;
  logic [3:0] dec_q;
  logic [15:0] accum_q, pcomp_q;
  logic [11:0] icomp_q, intgrl_q, error_q, lft_q, rht_q;
  logic busy_q, done_q, last, windup_hold;
  assign last = cnt_q == 2'(MULT_CYC - 1);
  assign {Accum, Pcomp, Icomp, Intgrl, Error} = {accum_q, pcomp_q, icomp_q, intgrl_q, error_q};
  assign {lft, rht, busy, done} = {lft_q, rht_q, busy_q, done_q};
  assign mult2 = 1'b0;
  assign mult4 = 1'b0;
`ifdef ANTI_WINDUP_EN
  logic sat_flag_q, clamp;
  assign clamp = (dst[15:11] != 5'b00000 && dst[15:11] != 5'b11111) || dst[11:0] == 12'h7FF || dst[11:0] == 12'h800;
  assign windup_hold = sat_flag_q;
  // sticky clamp flag: set by a clamped motor result, cleared as the next update integrates
  always_ff @(posedge clk) begin
    if (rst) sat_flag_q <= 1'b0;
    else if (state_q == INTG) sat_flag_q <= 1'b0;
    else if ((state_q == RHT || state_q == LFT) && clamp) sat_flag_q <= 1'b1;
  end
`else
  assign windup_hold = 1'b0;
`endif
  // decode ALU selects/ops for the current step and choose the next step
  always_comb begin
    state_d = state_q;
    src0sel = 3'd0;
    src1sel = 3'd0;
    multiply = 1'b0;
    sub = 1'b0;
    saturate = 1'b0;
    case (state_q)
      IDLE:  state_d = go ? INTG : IDLE;
      INTG:  begin src0sel = 3'd1; src1sel = 3'd3; saturate = 1'b1; state_d = ICOMP; end
      ICOMP: begin src0sel = 3'd1; src1sel = 3'd1; multiply = 1'b1; state_d = last ? PCOMP : ICOMP; end
      PCOMP: begin src0sel = 3'd4; src1sel = 3'd2; multiply = 1'b1; state_d = last ? ACC_R : PCOMP; end
      ACC_R: begin src0sel = 3'd3; src1sel = 3'd4; sub = 1'b1; state_d = RHT; end
      RHT:   begin src0sel = 3'd2; src1sel = 3'd0; sub = 1'b1; saturate = 1'b1; state_d = ACC_L; end
      ACC_L: begin src0sel = 3'd3; src1sel = 3'd4; state_d = LFT; end
      LFT:   begin src0sel = 3'd2; src1sel = 3'd0; saturate = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end
  // step register plus capture of the ALU result into the step's target register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      dec_q <= 4'd0;
      {accum_q, pcomp_q, icomp_q, intgrl_q, error_q} <= '0;
      {lft_q, rht_q, busy_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
      done_q <= state_q == LFT;
      case (state_q)
        IDLE: if (go) begin
          error_q <= err_in;
          busy_q <= 1'b1;
        end
        INTG: if (dec_q == 4'(INT_DEC - 1)) begin
          dec_q <= 4'd0;
          if (!windup_hold) intgrl_q <= dst[11:0];
        end else dec_q <= dec_q + 4'd1;
        ICOMP: if (last) icomp_q <= dst[11:0];
        PCOMP: if (last) pcomp_q <= dst;
        ACC_R, ACC_L: accum_q <= dst;
        RHT: rht_q <= dst[11:0];
        LFT: begin
          lft_q <= dst[11:0];
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
